booth_mult_seq: RTL and testbench

- Sequential radix-4 Booth multiplier controller for the calculator's multiply path.
- Accepts an 8-bit unsigned multiplicand and an 8-bit two's-complement multiplier over a valid/ready handshake.
- Contains one internal booth_encoder instance (8-bit x, 3-bit operand, 16-bit partial product). It steps that encoder through the multiplier's Booth groups, one group per clock, and accumulates a 16-bit signed product.
- An optional early-termination mode shortens latency for small-magnitude multipliers.

---
 rtl/booth_mult_seq_if.sv | 23 ++
 rtl/booth_mult_seq.sv | 122 ++++++++++++
 tb/tb_booth_mult_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Operand/product handshake bundle for the sequential Booth multiplier.
// The multiplier sits on the slave side; the requester drives the master side.
interface booth_mult_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [1:0]  grp;

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, product, busy, grp
  );

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, product, busy, grp
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Radix-4 Booth multiplier: unsigned 8-bit A times signed 8-bit B, one Booth
// group per clock into a 16-bit accumulator, with optional early termination.
module booth_encoder (
  input  logic [7:0]  x_i,
  input  logic [2:0]  op_i,
  output logic [15:0] pp_o
);
  logic [15:0] xe;

  assign xe = {8'b0, x_i};

  always_comb begin
    pp_o = '0;
    case (op_i)
      3'b001, 3'b010: pp_o = xe;
      3'b011:         pp_o = xe << 1;
      3'b100:         pp_o = -(xe << 1);
      3'b101, 3'b110: pp_o = -xe;
      default:        pp_o = '0;
    endcase
  end
endmodule

module booth_mult_seq #(
  parameter int unsigned EARLY_TERM = 0
) (
  input logic             clk,
  input logic             rst,
  booth_mult_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc_q;
  logic [1:0]  grp_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        out_valid_q;

  logic [8:0]        b_ext;
  logic [2:0]        op;
  logic [15:0]       pp;
  logic [15:0]       acc_d;
  logic signed [7:0] b_upper;
  logic              upper_same;
  logic              stop_d;

  // B[-1] = 0 is the appended LSB, so group g starts at bit 2g of b_ext.
  assign b_ext = {b_q, 1'b0};
  assign op    = b_ext[{grp_q, 1'b0} +: 3];

  booth_encoder u_enc (
    .x_i  (a_q),
    .op_i (op),
    .pp_o (pp)
  );

  assign acc_d = acc_q + (pp << {grp_q, 1'b0});

  // Remaining groups all encode zero once B[7:2g+1] is a pure sign extension.
  assign b_upper    = $signed(b_q) >>> ({grp_q, 1'b0} + 3'd1);
  assign upper_same = (b_upper == '0) || (b_upper == '1);
  assign stop_d     = (grp_q == 2'd3) || ((EARLY_TERM != 0) && upper_same);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      grp_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a_in;
            b_q        <= bus.b_in;
            acc_q      <= '0;
            grp_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          if (stop_d) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            grp_q <= grp_q + 2'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = acc_q;
  assign bus.busy      = busy_q;
  assign bus.grp       = grp_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomized checks of booth_mult_seq with EARLY_TERM=0 and =1
// side by side; sel routes the shared stimulus to one instance at a time.
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   sel = 1'b0;

  logic        in_valid  = 1'b0;
  logic [7:0]  a_in      = '0;
  logic [7:0]  b_in      = '0;
  logic        out_ready = 1'b0;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] product;
  logic        busy;
  logic [1:0]  grp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mult_seq_if if0 ();
  booth_mult_seq_if if1 ();

  assign if0.in_valid  = in_valid & (sel == 1'b0);
  assign if0.out_ready = out_ready & (sel == 1'b0);
  assign if0.a_in      = a_in;
  assign if0.b_in      = b_in;
  assign if1.in_valid  = in_valid & (sel == 1'b1);
  assign if1.out_ready = out_ready & (sel == 1'b1);
  assign if1.a_in      = a_in;
  assign if1.b_in      = b_in;

  assign in_ready  = sel ? if1.in_ready  : if0.in_ready;
  assign out_valid = sel ? if1.out_valid : if0.out_valid;
  assign product   = sel ? if1.product   : if0.product;
  assign busy      = sel ? if1.busy      : if0.busy;
  assign grp       = sel ? if1.grp       : if0.grp;

  booth_mult_seq #(.EARLY_TERM(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  booth_mult_seq #(.EARLY_TERM(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // Starts in IDLE at posedge+1; returns edges from accept to out_valid,
  // cycles busy was seen high, and the product; ends back in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt, output logic [15:0] prod);
    in_valid = 1'b1; a_in = a; b_in = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    prod = product;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; a_in = 8'd5; b_in = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", s, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", s, out_valid); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product[%0d] got=%h exp=0000", s, product); end
      checks++; if (busy !== 1'b0 || grp !== 2'd0) begin errors++; $display("FAIL reset_busy_grp[%0d] got=%b/%0d exp=0/0", s, busy, grp); end
    end
    sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    sel = 1'b0;
    in_valid = 1'b1; a_in = 8'd10; b_in = 8'hFF; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_out_valid got=%b exp=0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL midrun_product got=%h exp=0000", product); end
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrun_no_output got=%b exp=0", seen); end
  endtask

  task automatic test_latency_full;
    int lat, bcnt; logic [15:0] p;
    sel = 1'b0;
    run_op(8'd23, 8'hFB, lat, bcnt, p);
    checks++; if (p !== 16'hFF8D) begin errors++; $display("FAIL full_23x-5_product got=%h exp=ff8d", p); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL full_23x-5_latency got=%0d exp=4", lat); end
    checks++; if (bcnt !== 4) begin errors++; $display("FAIL full_23x-5_busy got=%0d exp=4", bcnt); end
    run_op(8'd10, 8'd3, lat, bcnt, p);
    checks++; if (p !== 16'h001E || lat !== 4) begin errors++; $display("FAIL full_10x3 got=%h/%0d exp=001e/4", p, lat); end
  endtask

  task automatic test_extremes;
    logic [7:0]  av [4] = '{8'd255, 8'd255, 8'd0,   8'd1};
    logic [7:0]  bv [4] = '{8'd127, 8'h80,  8'hB3,  8'h80};
    logic [15:0] ev [4] = '{16'h7E81, 16'h8080, 16'h0000, 16'hFF80};
    int lat, bcnt; logic [15:0] p;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      for (int i = 0; i < 4; i++) begin
        run_op(av[i], bv[i], lat, bcnt, p);
        checks++;
        if (p !== ev[i]) begin errors++; $display("FAIL extreme[%0d][%0d] a=%0d b=%h got=%h exp=%h", s, i, av[i], bv[i], p, ev[i]); end
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure;
    int n;
    sel = 1'b0;
    in_valid = 1'b1; a_in = 8'd23; b_in = 8'hFB; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_timeout got=%b exp=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a_in = 8'd99; b_in = 8'd99;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || product !== 16'hFF8D || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] ov=%b prod=%h rdy=%b busy=%b exp=1/ff8d/0/0", i, out_valid, product, in_ready, busy);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'hFF8D) begin
      errors++; $display("FAIL bp_release ov=%b rdy=%b prod=%h exp=0/1/ff8d", out_valid, in_ready, product);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_pulse busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    sel = 1'b0;
    in_valid = 1'b1; a_in = 8'd7; b_in = 8'd6; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    // Offer the next operands in the very cycle DONE is left.
    in_valid = 1'b1; a_in = 8'd3; b_in = 8'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || product !== 16'd42) begin
      errors++; $display("FAIL b2b_not_taken rdy=%b busy=%b prod=%h exp=1/0/002a", in_ready, busy, product);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_taken busy=%b exp=1", busy); end
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (product !== 16'h0009) begin errors++; $display("FAIL b2b_product got=%h exp=0009", product); end
    @(posedge clk); #1;
  endtask

  task automatic test_early_term;
    logic [7:0]  bv [4] = '{8'd3,     8'hFF,    8'd64,    8'd0};
    logic [15:0] ev [4] = '{16'h001E, 16'hFFF6, 16'h0280, 16'h0000};
    int          lv [4] = '{2, 1, 4, 1};
    int lat, bcnt; logic [15:0] p;
    sel = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      run_op(8'd10, bv[i], lat, bcnt, p);
      checks++;
      if (p !== ev[i]) begin errors++; $display("FAIL et_product[%0d] b=%h got=%h exp=%h", i, bv[i], p, ev[i]); end
      checks++;
      if (lat !== lv[i] || bcnt !== lv[i]) begin errors++; $display("FAIL et_latency[%0d] b=%h got=%0d/%0d exp=%0d", i, bv[i], lat, bcnt, lv[i]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_random_sweep(input bit et);
    logic [15:0] q[$];
    logic [15:0] exp;
    int acc_n;
    int cyc;
    acc_n = 0; cyc = 0;
    sel = et; #1;
    while ((acc_n < 1000 || q.size() != 0) && cyc < 40000) begin
      if (acc_n < 1000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a_in = 8'($urandom);
        b_in = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL sweep[%0d] unexpected output got=%h", et, product);
        end else begin
          exp = q.pop_front();
          if (product !== exp) begin errors++; $display("FAIL sweep[%0d] product got=%h exp=%h", et, product, exp); end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(16'(int'(a_in) * int'($signed(b_in))));
        acc_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (acc_n != 1000 || q.size() != 0) begin
      errors++; $display("FAIL sweep[%0d] timeout accepted=%0d pending=%0d exp=1000/0", et, acc_n, q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_run();
    test_latency_full();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_early_term();
    test_random_sweep(1'b0);
    test_random_sweep(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
